// File: rtl/free_list_pkg.sv
// Shared rename constants for the explicit-renaming core.
//   PHYS_REG_BITS   : width of a physical register index
//   ARCH_REG_BITS   : width of an architectural register index
//   NUM_ARCH_REGS   : architectural registers, mapped to phys 0..N-1 at reset
//   FREE_LIST_DEPTH : registers left over for renaming
package free_list_pkg;

  localparam int PHYS_REG_BITS   = 6;
  localparam int ARCH_REG_BITS   = 5;
  localparam int NUM_ARCH_REGS   = 32;
  localparam int NUM_PHYS_REGS   = 2 ** PHYS_REG_BITS;
  localparam int FREE_LIST_DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;

endpackage

// File: rtl/free_list.sv
// Circular list of free physical register indices.
// Dispatch takes the head entry (show-ahead on pd_alloc). Commit appends the
// stale mapping at the tail and advances commit_head. A branch flush moves
// head back to commit_head, returning every speculative allocation at once.
//
// Ports:
//   clk                  : clock, all state on posedge
//   rst                  : synchronous active-high reset
//   alloc_req            : dispatch consumes pd_alloc this cycle
//   pd_alloc             : head entry, '0 when empty
//   empty                : no free register available
//   commit_we            : commit returns pd_free to the list
//   pd_free              : stale physical register being released
//   global_branch_signal : mispredict flush
//   free_count           : number of free entries
module free_list #(
  parameter int PHYS_REG_BITS = free_list_pkg::PHYS_REG_BITS,
  parameter int NUM_ARCH_REGS = free_list_pkg::NUM_ARCH_REGS,
  parameter int DEPTH         = free_list_pkg::FREE_LIST_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_req,
  output logic [PHYS_REG_BITS-1:0] pd_alloc,
  output logic                     empty,
  input  logic                     commit_we,
  input  logic [PHYS_REG_BITS-1:0] pd_free,
  input  logic                     global_branch_signal,
  output logic [$clog2(DEPTH):0]   free_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PHYS_REG_BITS-1:0] mem [DEPTH];
  logic [PTR_W-1:0]         head;
  logic [PTR_W-1:0]         tail;
  logic [PTR_W-1:0]         commit_head;

  logic full;
  logic do_alloc;
  logic do_commit;

  assign free_count = tail - head;
  assign empty      = (free_count == '0);
  // Same slot, opposite lap: the tail is a full lap ahead of the head.
  assign full       = (tail[IDX_W-1:0] == head[IDX_W-1:0]) &&
                      (tail[IDX_W] != head[IDX_W]);
  assign pd_alloc   = empty ? '0 : mem[head[IDX_W-1:0]];

  // A flush discards this cycle's dispatch; a commit into a full list has
  // nowhere to go and is dropped.
  assign do_alloc  = alloc_req && !empty && !global_branch_signal;
  assign do_commit = commit_we && !full;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= PHYS_REG_BITS'(NUM_ARCH_REGS + i);
      end
      head        <= '0;
      commit_head <= '0;
      tail        <= {1'b1, {IDX_W{1'b0}}};
    end else begin
      if (do_commit) begin
        mem[tail[IDX_W-1:0]] <= pd_free;
        tail                 <= tail + 1'b1;
        commit_head          <= commit_head + 1'b1;
      end
      // Tail never overtakes commit_head, so the slots between commit_head
      // and head still hold the speculatively allocated registers.
      if (global_branch_signal) begin
        head <= do_commit ? commit_head + 1'b1 : commit_head;
      end else if (do_alloc) begin
        head <= head + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_free_list.sv
module tb_free_list;
  import free_list_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     alloc_req = 1'b0;
  logic [PHYS_REG_BITS-1:0] pd_alloc;
  logic                     empty;
  logic                     commit_we = 1'b0;
  logic [PHYS_REG_BITS-1:0] pd_free = '0;
  logic                     global_branch_signal = 1'b0;
  logic [5:0]               free_count;

  int checks = 0;
  int errors = 0;
  logic allow_proto = 1'b0;

  free_list dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .pd_alloc(pd_alloc),
    .empty(empty), .commit_we(commit_we), .pd_free(pd_free),
    .global_branch_signal(global_branch_signal), .free_count(free_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Protocol monitor on the stimulus actually applied.
  always @(posedge clk) begin
    if (!rst && !allow_proto) begin
      if (alloc_req) begin
        checks++;
        if (empty) begin
          errors++;
          $display("FAIL proto_alloc_empty: alloc_req=1 while empty=%0d", empty);
        end
      end
      if (commit_we) begin
        checks++;
        if (pd_free == 0 || free_count == 6'd32) begin
          errors++;
          $display("FAIL proto_commit: pd_free=%0d free_count=%0d, need pd_free!=0 and not full",
                   pd_free, free_count);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [5:0] exp_pd, input logic exp_e,
                     input logic [5:0] exp_cnt);
    checks += 3;
    if (pd_alloc !== exp_pd) begin
      errors++;
      $display("FAIL %s pd_alloc: got %0d want %0d", nm, pd_alloc, exp_pd);
    end
    if (empty !== exp_e) begin
      errors++;
      $display("FAIL %s empty: got %0d want %0d", nm, empty, exp_e);
    end
    if (free_count !== exp_cnt) begin
      errors++;
      $display("FAIL %s free_count: got %0d want %0d", nm, free_count, exp_cnt);
    end
  endtask

  task automatic step(input logic r, input logic a, input logic c, input logic f,
                      input logic [5:0] pd);
    rst = r; alloc_req = a; commit_we = c; global_branch_signal = f; pd_free = pd;
    @(posedge clk); #1;
    rst = 1'b0; alloc_req = 1'b0; commit_we = 1'b0; global_branch_signal = 1'b0; pd_free = '0;
  endtask

  typedef struct {
    logic       r, a, c, f, proto;
    logic [5:0] pd;
    logic [5:0] exp_pd;
    logic       exp_e;
    logic [5:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, a, c, f, input logic [5:0] pd,
                              input logic [5:0] exp_pd, input logic exp_e,
                              input logic [5:0] exp_cnt, input logic proto = 1'b0);
    vec_t v;
    v.r = r; v.a = a; v.c = c; v.f = f; v.pd = pd; v.proto = proto;
    v.exp_pd = exp_pd; v.exp_e = exp_e; v.exp_cnt = exp_cnt;
    vecs.push_back(v);
  endfunction

  // Reference model: ordered queue of free regs, queue of in-flight
  // (allocated, uncommitted) renames, and the committed architectural map.
  logic [5:0] free_q[$];
  logic [5:0] infl_pd[$];
  logic [4:0] infl_rd[$];
  logic [5:0] rrat[32];

  function automatic void model_reset();
    free_q.delete(); infl_pd.delete(); infl_rd.delete();
    for (int i = 0; i < 32; i++) free_q.push_back(6'(32 + i));
    for (int i = 0; i < 32; i++) rrat[i] = 6'(i);
  endfunction

  initial begin
    // ---------------- table-driven directed vectors ----------------
    // Reset state, then three allocations.
    add(1,0,0,0,0, 32,0,32);
    add(0,1,0,0,0, 33,0,31);
    add(0,1,0,0,0, 34,0,30);
    add(0,1,0,0,0, 35,0,29);
    // Commit into a full list is dropped.
    add(1,0,0,0,0, 32,0,32);
    add(0,0,1,0,5, 32,0,32, 1'b1);
    // Alloc 4, commit one, flush: speculative 33..35 come back.
    add(1,0,0,0,0, 32,0,32);
    add(0,1,0,0,0, 33,0,31);
    add(0,1,0,0,0, 34,0,30);
    add(0,1,0,0,0, 35,0,29);
    add(0,1,0,0,0, 36,0,28);
    add(0,0,1,0,3, 36,0,29);
    add(0,0,0,1,0, 33,0,32);
    add(0,1,0,0,0, 34,0,31);
    add(0,1,0,0,0, 35,0,30);
    add(0,1,0,0,0, 36,0,29);
    // Flush + commit + alloc in one cycle: commit kept, alloc dropped.
    add(1,0,0,0,0, 32,0,32);
    add(0,1,0,0,0, 33,0,31);
    add(0,1,0,0,0, 34,0,30);
    add(0,1,0,0,0, 35,0,29);
    add(0,1,0,0,0, 36,0,28);
    add(0,0,1,0,3, 36,0,29);
    add(0,1,1,1,9, 34,0,32);
    add(0,1,0,0,0, 35,0,31);

    for (int k = 0; k < vecs.size(); k++) begin
      allow_proto = vecs[k].proto;
      step(vecs[k].r, vecs[k].a, vecs[k].c, vecs[k].f, vecs[k].pd);
      allow_proto = 1'b0;
      chk($sformatf("vec%0d", k), vecs[k].exp_pd, vecs[k].exp_e, vecs[k].exp_cnt);
    end

    // ---------------- drain to empty, extra alloc, commit without bypass ----
    step(1,0,0,0,0);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("drain%0d", i), 6'(32 + i), 1'b0, 6'(32 - i));
      step(0,1,0,0,0);
    end
    chk("empty", 6'd0, 1'b1, 6'd0);
    allow_proto = 1'b1;
    step(0,1,0,0,0);
    allow_proto = 1'b0;
    chk("extra_alloc", 6'd0, 1'b1, 6'd0);
    commit_we = 1'b1; pd_free = 6'd5;
    #1;
    chk("no_bypass", 6'd0, 1'b1, 6'd0);
    @(posedge clk); #1;
    commit_we = 1'b0; pd_free = '0;
    chk("freed_5", 6'd5, 1'b0, 6'd1);

    // ---------------- simultaneous alloc + commit ----------------
    step(1,0,0,0,0);
    for (int i = 0; i < 22; i++) step(0,1,0,0,0);
    chk("cnt10", 6'd54, 1'b0, 6'd10);
    step(0,1,1,0,7);
    chk("alloc_commit", 6'd55, 1'b0, 6'd10);
    for (int i = 0; i < 9; i++) step(0,1,0,0,0);
    chk("appended_7", 6'd7, 1'b0, 6'd1);

    // ---------------- randomized run against the model ----------------
    step(1,0,0,0,0);
    model_reset();
    for (int cyc = 0; cyc < 300; cyc++) begin
      logic r, a, c, f;
      logic [5:0] pd;
      logic [4:0] rd;
      int seen[64];
      r  = (cyc == 150);
      a  = (free_q.size() > 0) && ($urandom_range(0, 99) < 60);
      c  = (infl_pd.size() > 0) && ($urandom_range(0, 99) < 45);
      f  = ($urandom_range(0, 99) < 5);
      pd = c ? rrat[infl_rd[0]] : 6'd0;
      rd = 5'($urandom_range(1, 31));
      step(r, a, c, f, pd);

      if (r) begin
        model_reset();
      end else begin
        if (c) begin
          rrat[infl_rd[0]] = infl_pd[0];
          void'(infl_pd.pop_front());
          void'(infl_rd.pop_front());
        end
        if (a && !f) begin
          infl_pd.push_back(free_q[0]);
          infl_rd.push_back(rd);
          void'(free_q.pop_front());
        end
        if (c) free_q.push_back(pd);
        if (f) begin
          free_q = {infl_pd, free_q};
          infl_pd.delete();
          infl_rd.delete();
        end
      end

      chk($sformatf("rand%0d", cyc), (free_q.size() > 0) ? free_q[0] : 6'd0,
          free_q.size() == 0, 6'(free_q.size()));

      // Every physical register is exactly once free, in flight or committed.
      for (int i = 0; i < 64; i++) seen[i] = 0;
      foreach (free_q[i])  seen[free_q[i]]++;
      foreach (infl_pd[i]) seen[infl_pd[i]]++;
      for (int i = 0; i < 32; i++) seen[rrat[i]]++;
      checks++;
      begin
        int bad;
        bad = 0;
        for (int i = 0; i < 64; i++) if (seen[i] != 1) bad++;
        if (bad != 0 || int'(free_count) + infl_pd.size() + 32 != 64) begin
          errors++;
          $display("FAIL rand%0d conservation: %0d regs not unique, free_count=%0d inflight=%0d, need sum 64",
                   cyc, bad, free_count, infl_pd.size());
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
